// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED PWM/blink block: register addresses,
// configuration reset values and the blink period table.
package led_pwm_pkg;

    // Register map seen through pwmAddr.
    localparam logic [1:0] ADDR_DUTY    = 2'b00;
    localparam logic [1:0] ADDR_BLINK   = 2'b01;
    localparam logic [1:0] ADDR_RESTART = 2'b10;

    // Configuration values after reset: full brightness, no blinking,
    // shortest blink period.  This makes the block transparent.
    localparam logic [7:0] DUTY_RST     = 8'hFF;
    localparam logic [2:0] BLINK_EN_RST = 3'b000;
    localparam logic [1:0] PERIOD_RST   = 2'b00;

    // LED groups of eight pins each.
    localparam int NUM_GROUPS = 3;

    // Number of PWM frames per blink half-period for each period code.
    // Seven bits so that 64 fits and blink_cnt+1 can be compared directly.
    function automatic logic [6:0] blink_limit(input logic [1:0] period);
        logic [6:0] limit;
        case (period)
            2'b00:   limit = 7'd8;
            2'b01:   limit = 7'd16;
            2'b10:   limit = 7'd32;
            default: limit = 7'd64;
        endcase
        return limit;
    endfunction

endpackage

// File: rtl/led_pwm_tick_gen.sv
// Prescaler: divides the system clock down to one PWM step per PRESCALE
// clocks.  tick is high for the single cycle in which the count sits at
// PRESCALE-1; clear restarts the count from zero on the next edge.
module tick_gen #(
    parameter int unsigned PRESCALE = 390
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] count;

    // Free-running modulo-PRESCALE counter, clear has priority over wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/led_pwm.sv
// LED brightness and blink controller.  An 8-bit PWM counter advanced by
// the prescaler tick sets brightness for all LEDs; a frame counter toggles
// a blink phase that gates the groups selected by blink_en.  Configuration
// is written through a small register port and read back combinationally.
module led_pwm
    import led_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 390
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] leds_in,
    input  logic        PWMCtrl,
    input  logic        ioWrite,
    input  logic [1:0]  pwmAddr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic [23:0] leds,
    output logic        blink_phase
);

    // Configuration registers.
    logic [7:0]  duty;
    logic [2:0]  blink_en;
    logic [1:0]  period;

    // Timing state.
    logic [7:0]  pwm_cnt;
    logic [5:0]  blink_cnt;

    logic        cfg_wr;
    logic        restart;
    logic        tick;
    logic        frame_end;
    logic        pwm_on;
    logic        blink_wrap;
    logic [23:0] led_next;

    // Bits of write_data that no register uses.
    logic        unused_wdata;
    assign unused_wdata = ^{write_data[15:6], write_data[3]};

    // A write happens only when this block is selected and strobed.
    assign cfg_wr  = PWMCtrl & ioWrite;
    assign restart = cfg_wr & (pwmAddr == ADDR_RESTART);

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (restart),
        .tick  (tick)
    );

    assign frame_end  = tick & (pwm_cnt == 8'hFF);

    // duty=FF is the only way to get a constant-on output, since the
    // compare alone would leave one dark step per frame.
    assign pwm_on     = (duty == 8'hFF) ? 1'b1 : (pwm_cnt < duty);

    // >= rather than == so that shortening the period below the current
    // count still wraps at the very next frame end.
    assign blink_wrap = ({1'b0, blink_cnt} + 7'd1) >= blink_limit(period);

    // Configuration register writes; restart and reserved addresses leave them alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            duty     <= DUTY_RST;
            blink_en <= BLINK_EN_RST;
            period   <= PERIOD_RST;
        end else if (cfg_wr) begin
            case (pwmAddr)
                ADDR_DUTY: begin
                    duty <= write_data[7:0];
                end
                ADDR_BLINK: begin
                    blink_en <= write_data[2:0];
                    period   <= write_data[5:4];
                end
                default: begin
                end
            endcase
        end
    end

    // PWM step counter; restart wins over a same-cycle tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= '0;
        end else if (restart) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // Blink frame counter and phase; restart wins over a same-cycle frame end.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (restart) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_end) begin
            if (blink_wrap) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 6'd1;
            end
        end
    end

    // Per-group gate: PWM brightness, then blink masking for enabled groups.
    always_comb begin
        led_next = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            led_next[g*8 +: 8] = {8{pwm_on & (~blink_en[g] | blink_phase)}} & leds_in[g*8 +: 8];
        end
    end

    // Registered pin drive, one clock behind leds_in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leds <= '0;
        end else begin
            leds <= led_next;
        end
    end

    // Combinational readback of the selected configuration register.
    always_comb begin
        read_data = 16'h0000;
        case (pwmAddr)
            ADDR_DUTY:  read_data = {8'h00, duty};
            ADDR_BLINK: read_data = {10'b0, period, 1'b0, blink_en};
            default:    read_data = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_led_pwm.sv
// Bench for led_pwm with PRESCALE=2.  A behavioural model tracks time since
// the last restart as one integer and derives prescaler/PWM position from it
// arithmetically; directed sequences pin the model with hand-computed values,
// then a long randomized run checks every cycle.
module tb_led_pwm;

    localparam int P     = 2;
    localparam int FRAME = P * 256;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] leds_in = 24'h0;
    logic        PWMCtrl = 1'b0;
    logic        ioWrite = 1'b0;
    logic [1:0]  pwmAddr = 2'b00;
    logic [15:0] write_data = 16'h0;
    logic [15:0] read_data;
    logic [23:0] leds;
    logic        blink_phase;

    int n_cmp  = 0;
    int n_fail = 0;

    led_pwm #(.PRESCALE(P)) dut (
        .clock       (clock),
        .reset       (reset),
        .leds_in     (leds_in),
        .PWMCtrl     (PWMCtrl),
        .ioWrite     (ioWrite),
        .pwmAddr     (pwmAddr),
        .write_data  (write_data),
        .read_data   (read_data),
        .leds        (leds),
        .blink_phase (blink_phase)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clock = ~clock;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    int          m_t;          // clocks since last restart, modulo one frame
    logic [7:0]  m_duty   = 8'hFF;
    logic [2:0]  m_en     = 3'b000;
    logic [1:0]  m_period = 2'b00;
    int          m_bcnt   = 0;
    logic        m_phase  = 1'b1;
    logic [23:0] exp_q[$];

    int          mp_step;
    bit          mp_frame_end;
    bit          mp_on;
    bit          mp_wr;
    logic [23:0] mp_leds;

    initial begin
        m_t = 0;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_t = 0; m_duty = 8'hFF; m_en = 3'b000; m_period = 2'b00;
                m_bcnt = 0; m_phase = 1'b1;
                exp_q.delete();
                exp_q.push_back(24'h0);
            end else begin
                mp_step      = (m_t / P) % 256;
                mp_frame_end = (m_t == FRAME - 1);
                mp_on        = (m_duty == 8'hFF) || (mp_step < int'(m_duty));
                for (int g = 0; g < 3; g++)
                    mp_leds[g*8 +: 8] = (mp_on && (!m_en[g] || m_phase)) ? leds_in[g*8 +: 8] : 8'h00;
                exp_q.push_back(mp_leds);
                mp_wr = PWMCtrl && ioWrite;
                if (mp_wr && pwmAddr == 2'd2) begin
                    m_t = 0; m_bcnt = 0; m_phase = 1'b1;
                end else begin
                    m_t = (m_t + 1) % FRAME;
                    if (mp_frame_end) begin
                        if (m_bcnt + 1 >= (8 << m_period)) begin
                            m_phase = !m_phase; m_bcnt = 0;
                        end else begin
                            m_bcnt = m_bcnt + 1;
                        end
                    end
                end
                if (mp_wr && pwmAddr == 2'd0) m_duty = write_data[7:0];
                if (mp_wr && pwmAddr == 2'd1) begin
                    m_en = write_data[2:0]; m_period = write_data[5:4];
                end
            end
        end
    end

    function automatic logic [15:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {8'h00, m_duty};
            2'd1:    return {10'b0, m_period, 1'b0, m_en};
            default: return 16'h0000;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison on the inactive edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) check("leds", {8'h0, leds}, {8'h0, exp_q.pop_front()});
        check("blink_phase", {31'h0, blink_phase}, {31'h0, m_phase});
        check("read_data", {16'h0, read_data}, {16'h0, model_rd(pwmAddr)});
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        PWMCtrl = 1'b1; ioWrite = 1'b1; pwmAddr = a; write_data = d;
        step();
        PWMCtrl = 1'b0; ioWrite = 1'b0;
    endtask

    task automatic wait_toggle(input int max_cyc, output int n, output bit ok);
        logic p0;
        p0 = blink_phase;
        n = 0; ok = 0;
        while (n < max_cyc && !ok) begin
            step();
            n++;
            if (blink_phase !== p0) ok = 1;
        end
    endtask

    // ---------------- stimulus ----------------
    int n;
    bit ok;
    int lit;
    bit prev_lit;

    initial begin
        leds_in = 24'hA5A5A5;

        // Reset values and transparency after release.
        repeat (3) step();
        check("rst_leds", {8'h0, leds}, 32'h0);
        check("rst_phase", {31'h0, blink_phase}, 32'h1);
        check("rst_duty_rd", {16'h0, read_data}, 32'h00FF);
        pwmAddr = 2'd1;
        #1 check("rst_blink_rd", {16'h0, read_data}, 32'h0);
        pwmAddr = 2'd0;
        reset = 1'b1;
        step(); step();
        check("release_leds", {8'h0, leds}, 32'hA5A5A5);
        repeat (20) step();
        check("release_hold", {8'h0, leds}, 32'hA5A5A5);

        // Duty 0x40: 128 lit clocks in every 512.
        leds_in = 24'hFFFFFF;
        cfg_write(2'd0, 16'h0040);
        check("duty40_rd", {16'h0, read_data}, 32'h0040);
        step();
        lit = 0;
        repeat (FRAME) begin step(); if (leds == 24'hFFFFFF) lit++; end
        check("duty40_lit", lit, 128);

        // Duty 0: permanently dark.
        cfg_write(2'd0, 16'h0000);
        step();
        lit = 0;
        repeat (FRAME) begin step(); if (leds != 24'h0) lit++; end
        check("duty0_lit", lit, 0);

        // Blink g0,g2 with period 00: half-period of 8 frames.
        cfg_write(2'd0, 16'h00FF);
        cfg_write(2'd1, 16'h0005);
        check("blink_rd", {16'h0, read_data}, 32'h0005);
        wait_toggle(5000, n, ok);
        check("blink_first_toggle_seen", {31'h0, ok}, 32'h1);
        step();
        check("blink_gated_leds", {8'h0, leds}, (m_phase == 1'b0) ? 32'h00FF00 : 32'hFFFFFF);
        wait_toggle(5000, n, ok);
        check("blink_interval", n + 1, 8 * FRAME);

        // Shrinking the period mid-count wraps at the next frame end.
        cfg_write(2'd1, 16'h0035);
        check("blink35_rd", {16'h0, read_data}, 32'h0035);
        n = 0;
        while (m_bcnt != 20 && n < 64 * FRAME) begin step(); n++; end
        check("bcnt20_reached", n < 64 * FRAME, 1);
        cfg_write(2'd1, 16'h0005);
        wait_toggle(FRAME + 4, n, ok);
        check("shrink_toggle_seen", {31'h0, ok}, 32'h1);
        check("shrink_toggle_delay", n, FRAME - 1);
        wait_toggle(5000, n, ok);
        check("shrink_next_interval", n, 8 * FRAME);

        // Restart on the frame-end cycle.
        cfg_write(2'd1, 16'h0000);
        cfg_write(2'd0, 16'h0001);
        n = 0;
        while (m_t != FRAME - 1 && n < FRAME + 4) begin step(); n++; end
        check("frame_end_aligned", n < FRAME + 4, 1);
        cfg_write(2'd2, 16'hBEEF);
        check("restart_phase", {31'h0, blink_phase}, 32'h1);
        step();
        check("restart_first_lit", {8'h0, leds}, 32'hFFFFFF);
        n = 0; ok = 0; prev_lit = 1'b1;
        while (!ok && n < 2 * FRAME) begin
            step(); n++;
            if (leds != 24'h0 && !prev_lit) ok = 1;
            prev_lit = (leds != 24'h0);
        end
        check("restart_next_frame", n, FRAME);

        // Asynchronous reset mid-blink.
        cfg_write(2'd0, 16'h0010);
        cfg_write(2'd1, 16'h0007);
        pwmAddr = 2'd0;
        n = 0;
        while (blink_phase !== 1'b0 && n < 10 * FRAME) begin step(); n++; end
        check("dark_phase_reached", {31'h0, blink_phase}, 32'h0);
        #1 reset = 1'b0;
        #1;
        check("async_rst_leds", {8'h0, leds}, 32'h0);
        check("async_rst_phase", {31'h0, blink_phase}, 32'h1);
        check("async_rst_duty", {16'h0, read_data}, 32'h00FF);
        step(); step();
        reset = 1'b1;
        step(); step();
        check("async_rst_transparent", {8'h0, leds}, 32'hFFFFFF);

        // Randomized traffic.
        for (int i = 0; i < 20000; i++) begin
            leds_in    = 24'($urandom);
            pwmAddr    = 2'($urandom_range(0, 3));
            write_data = 16'($urandom);
            PWMCtrl    = 1'($urandom_range(0, 1));
            ioWrite    = ($urandom_range(0, 47) == 0);
            if (ioWrite && pwmAddr == 2'd2 && $urandom_range(0, 7) != 0) pwmAddr = 2'd3;
            if (i == 10000) begin
                #1 reset = 1'b0;
                step();
                reset = 1'b1;
            end
            step();
        end
        PWMCtrl = 1'b0; ioWrite = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pwm.md
LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 Parameter PRESCALE, default 390; clock cycles per PWM step, legal range 1..65535.
REQ-002 clock  input  1  system clock; every register updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 resets immediately, release is synchronous to clock.
REQ-004 leds_in  input  24  LED pattern from the led output register, in three groups: g0=[7:0], g1=[15:8], g2=[23:16].
REQ-005 PWMCtrl  input  1  address-decode select for this block, from the memory/IO controller.
REQ-006 ioWrite  input  1  IO write strobe; a config write occurs only when PWMCtrl=1 and ioWrite=1.
REQ-007 pwmAddr  input  2  register select: 00 duty, 01 blink, 10 restart, 11 reserved.
REQ-008 write_data  input  16  write data bus.
REQ-009 read_data  output  16  combinational readback of the register selected by pwmAddr.
REQ-010 leds  output  24  board LED pins, registered.
REQ-011 blink_phase  output  1  current blink phase, 1 = lit half.

Function
REQ-012 Prescaler counts 0..PRESCALE-1 and wraps; tick is a one-cycle pulse on the cycle the count equals PRESCALE-1.
REQ-013 8-bit pwm_cnt increments on each tick and wraps 255->0; frame_end = tick AND pwm_cnt==255.
REQ-014 pwm_on = 1 when duty==8'hFF, otherwise pwm_on = (pwm_cnt < duty), an unsigned 8-bit compare; duty=0 therefore gives constant off.
REQ-015 6-bit blink_cnt increments on each frame_end; limit is 8, 16, 32 or 64 frames for period = 00, 01, 10, 11.
REQ-016 On frame_end with blink_cnt+1 >= limit: blink_phase toggles and blink_cnt clears. The >= compare means shrinking period mid-count toggles at the next frame_end.
REQ-017 Per group g: leds[g] <= {8{pwm_on AND (NOT blink_en[g] OR blink_phase)}} AND leds_in[g]; latency is one clock from leds_in.
REQ-018 Write to addr 00: duty <= write_data[7:0]; takes effect from the next clock's compare, with no frame alignment.
REQ-019 Write to addr 01: blink_en <= write_data[2:0] and period <= write_data[5:4]; other bits are ignored.
REQ-020 Write to addr 10: prescaler, pwm_cnt and blink_cnt clear to 0 and blink_phase is set to 1; write_data is ignored; this write has priority over the same-cycle tick and frame_end.
REQ-021 Write to addr 11 has no effect.
REQ-022 No write when PWMCtrl=0 or ioWrite=0; all config registers hold.
REQ-023 read_data: addr 00 = {8'h00, duty}; addr 01 = {10'b0, period, 1'b0, blink_en}; addr 10 and 11 = 16'h0000.
REQ-024 Counters run continuously, independent of leds_in and of writes other than addr 10.

Reset
REQ-025 While reset=0: duty=8'hFF, blink_en=3'b000, period=2'b00, prescaler=0, pwm_cnt=0, blink_cnt=0, blink_phase=1, leds=24'h000000.
REQ-026 After reset the block is transparent: leds follows leds_in with one-cycle latency.
REQ-027 Asserting reset mid-frame or mid-blink aborts immediately to the REQ-025 values, with no partial-frame completion.

Structure
REQ-028 Shared package led_pwm_pkg holds the address constants (ADDR_DUTY, ADDR_BLINK, ADDR_RESTART), the blink limit table, and the reset values for duty, blink_en and period.
REQ-029 One sub-module, tick_gen (PRESCALE parameter, clock, reset, clear, tick), implements the prescaler; clear is driven by the addr-10 write.
REQ-030 All other logic lives in led_pwm; no latches; read_data is the only combinational output.

Verification (PRESCALE=2)
REQ-031 Reset with leds_in=24'hA5A5A5 -> leds=0 during reset; 24'hA5A5A5 on the second clock after release, held constant.
REQ-032 Write duty=8'h40 -> each group is lit for exactly 64 of every 256 ticks (128 of 512 clocks); duty=8'h00 -> leds=0 permanently.
REQ-033 Write blink: write_data=16'h0005 (g0, g2 blink, period 00) -> g0 and g2 toggle every 8 frames (4096 clocks); g1 stays steady; read_data at addr 01 = 16'h0005.
REQ-034 blink_cnt=20 with period 11, then write period 00 -> toggle at the next frame_end and blink_cnt returns to 0.
REQ-035 Restart write on the same cycle as frame_end -> counters 0, blink_phase=1, no toggle; the next frame_end occurs 512 clocks later.
REQ-036 Assert reset while blink_phase=0 and duty=8'h10 -> all registers take the REQ-025 values in the same cycle, without waiting for a clock edge.
